// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

    // Value presented on ins_data out of reset
    localparam logic [31:0] INS_RESET = 32'h0000_0000;

endpackage

// File: rtl/fetch_timeout_counter.sv
// WAIT-state watchdog for the fetch unit: counts cycles spent waiting for
// read data and flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = enable && (cnt_q == CNT_LAST);

    // Count waiting cycles; held at zero outside WAIT
    always_ff @(posedge CLK) begin
        if (Reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples pc, performs a req/gnt/rvalid read from
// instruction memory, holds the word for decode and pulses PCWrite once
// decode accepts it. Redirect flushes any fetch in flight.
// Optional build macro FETCH_TIMEOUT_EN adds a sticky WAIT-state timeout
// fault on fetch_err; without it fetch_err is tied low.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              Redirect,
    output logic              PCWrite,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              ins_valid,
    output logic [31:0]       ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              ins_ready,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              pcwrite_q, pcwrite_d;
    logic              err_q;

    // Word alignment discards the byte offset
    logic [1:0] unused_pc_lsb;
    assign unused_pc_lsb = pc[1:0];

`ifdef FETCH_TIMEOUT_EN
    logic err_d;
    logic timeout_expire;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK   (CLK),
        .Reset (Reset),
        .clear (state_q != FETCH_WAIT),
        .enable((state_q == FETCH_WAIT) && !mem_rvalid),
        .expire(timeout_expire)
    );

    // Sticky fault flag; only Reset clears it
    always_ff @(posedge CLK) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err_q          = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= FETCH_IDLE;
            drop_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            data_q    <= INS_RESET;
            ipc_q     <= '0;
            pcwrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ipc_q     <= ipc_d;
            pcwrite_q <= pcwrite_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        ipc_d     = ipc_q;
        pcwrite_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            FETCH_IDLE: begin
                // After a timeout fault no further request is issued
                if (!err_q) begin
                    addr_d  = {pc[ADDR_W-1:2], 2'b00};
                    req_d   = 1'b1;
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (Redirect) begin
                    drop_d = 1'b1;
                end
                if (mem_gnt) begin
                    req_d   = 1'b0;
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (mem_rvalid) begin
                    // A redirect arriving with the data also makes it stale
                    if (drop_q || Redirect) begin
                        drop_d  = 1'b0;
                        state_d = FETCH_IDLE;
                    end else begin
                        data_d  = mem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        state_d = FETCH_HOLD;
                    end
                end else begin
                    if (Redirect) begin
                        drop_d = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (timeout_expire) begin
                        err_d   = 1'b1;
                        drop_d  = 1'b0;
                        state_d = FETCH_IDLE;
                    end
`endif
                end
            end
            FETCH_HOLD: begin
                // Redirect wins over a simultaneous handshake
                if (Redirect) begin
                    valid_d = 1'b0;
                    state_d = FETCH_IDLE;
                end else if (ins_ready) begin
                    valid_d   = 1'b0;
                    pcwrite_d = 1'b1;
                    state_d   = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    assign PCWrite   = pcwrite_q;
    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign ins_valid = valid_q;
    assign ins_data  = data_q;
    assign ins_pc    = ipc_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
    localparam int TO = 8;
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam int TO = 255;
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        CLK;
    logic        Reset;
    logic [31:0] pc;
    logic        Redirect;
    logic        PCWrite;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        fetch_err;

    instr_fetch_unit #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .pc        (pc),
        .Redirect  (Redirect),
        .PCWrite   (PCWrite),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .ins_valid (ins_valid),
        .ins_data  (ins_data),
        .ins_pc    (ins_pc),
        .ins_ready (ins_ready),
        .fetch_err (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: what the fetch unit owes the world right now
    logic        m_req;      // request outstanding, not yet granted
    logic [31:0] m_addr;
    logic        m_out;      // granted, data not yet returned
    logic        m_drop;     // data of the outstanding fetch is stale
    logic        m_valid;    // instruction offered to decode
    logic [31:0] m_data;
    logic [31:0] m_ipc;
    logic        m_pcw;
    logic        m_err;
    int          m_wcnt;
    logic [31:0] pc_next;    // bench-side PC register
    int          mem_cnt;    // cycles until memory returns data, -1 idle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs, drive inputs, advance the model
    task automatic step(input logic rst, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic rdy, input logic redir,
                        input logic [31:0] tgt);
        logic n_pcw;
        @(negedge CLK);
        pc = pc_next;
        chk("mem_req", {31'b0, mem_req}, {31'b0, m_req});
        chk("mem_addr", mem_addr, m_addr);
        chk("ins_valid", {31'b0, ins_valid}, {31'b0, m_valid});
        chk("ins_data", ins_data, m_data);
        chk("ins_pc", ins_pc, m_ipc);
        chk("PCWrite", {31'b0, PCWrite}, {31'b0, m_pcw});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
        Reset      = rst;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rd;
        ins_ready  = rdy;
        Redirect   = redir;
        if (m_pcw) pc_next = pc + 32'd4;
        else if (redir) pc_next = tgt;
        if (rst) begin
            m_req = 0; m_addr = 0; m_out = 0; m_drop = 0; m_valid = 0;
            m_data = 0; m_ipc = 0; m_pcw = 0; m_err = 0; m_wcnt = 0;
        end else begin
            n_pcw = 1'b0;
            if (m_valid) begin
                if (redir) m_valid = 1'b0;
                else if (rdy) begin
                    m_valid = 1'b0;
                    n_pcw   = 1'b1;
                end
            end else if (m_out) begin
                if (rv) begin
                    m_out = 1'b0;
                    if (m_drop || redir) m_drop = 1'b0;
                    else begin
                        m_valid = 1'b1;
                        m_data  = rd;
                        m_ipc   = m_addr;
                    end
                end else begin
                    if (redir) m_drop = 1'b1;
                    m_wcnt++;
                    if (TIMEOUT_ON && m_wcnt >= TO) begin
                        m_err  = 1'b1;
                        m_out  = 1'b0;
                        m_drop = 1'b0;
                    end
                end
            end else if (m_req) begin
                if (redir) m_drop = 1'b1;
                if (gnt) begin
                    m_req  = 1'b0;
                    m_out  = 1'b1;
                    m_wcnt = 0;
                end
            end else if (!m_err) begin
                m_req  = 1'b1;
                m_addr = {pc[31:2], 2'b00};
            end
            m_pcw = n_pcw;
        end
    endtask

    task automatic idle_step(input logic gnt, input logic rv, input logic [31:0] rd,
                             input logic rdy);
        step(1'b0, gnt, rv, rd, rdy, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        mem_cnt = -1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_next = v;
    endtask

    int req_cycles;
    int pcw_count;
    int pcw_early;

    initial begin
        Reset = 1'b1; pc = 0; Redirect = 0; mem_gnt = 0; mem_rvalid = 0;
        mem_rdata = 0; ins_ready = 0; pc_next = 0; mem_cnt = -1;
        m_req = 0; m_addr = 0; m_out = 0; m_drop = 0; m_valid = 0;
        m_data = 0; m_ipc = 0; m_pcw = 0; m_err = 0; m_wcnt = 0;
        @(posedge CLK);

        // Best-case latency
        do_reset();
        set_pc(32'h0040_0003);
        idle_step(0, 0, 0, 1);                          // c0
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        idle_step(1, 0, 0, 1);                          // c1
        chk("lat_mem_req", {31'b0, mem_req}, 32'd1);
        chk("lat_mem_addr", mem_addr, 32'h0040_0000);
        idle_step(0, 1, 32'h2008_0005, 1);              // c2
        idle_step(0, 0, 0, 1);                          // c3
        chk("lat_ins_valid", {31'b0, ins_valid}, 32'd1);
        chk("lat_ins_pc", ins_pc, 32'h0040_0000);
        chk("lat_ins_data", ins_data, 32'h2008_0005);
        chk("lat_pcw_c3", {31'b0, PCWrite}, 32'd0);
        idle_step(0, 0, 0, 1);                          // c4
        chk("lat_pcw_c4", {31'b0, PCWrite}, 32'd1);
        idle_step(0, 0, 0, 0);                          // c5
        chk("lat_pcw_c5", {31'b0, PCWrite}, 32'd0);

        // Delayed grant, then decode stalls for 5 cycles
        do_reset();
        set_pc(32'h0040_0040);
        req_cycles = 0; pcw_count = 0; pcw_early = 0;
        for (int c = 0; c <= 12; c++) begin
            idle_step(c == 4, c == 5, 32'h8C08_0000, c == 11);
            if (mem_req && mem_addr == 32'h0040_0040) req_cycles++;
            if (PCWrite) begin
                pcw_count++;
                if (c <= 11) pcw_early++;
            end
            if (c == 10) chk("stall_ins_data", ins_data, 32'h8C08_0000);
        end
        chk("gnt_req_cycles", req_cycles, 32'd4);
        chk("stall_no_early_pcw", pcw_early, 32'd0);
        chk("stall_pcw_pulses", pcw_count, 32'd1);

        // Redirect during WAIT discards the returning word
        do_reset();
        set_pc(32'h0040_0080);
        idle_step(0, 0, 0, 1);                          // c0
        idle_step(1, 0, 0, 1);                          // c1
        step(0, 0, 0, 0, 1, 1, 32'h0040_0100);          // c2
        idle_step(0, 1, 32'hDEAD_BEEF, 1);              // c3
        chk("flush_valid_c3", {31'b0, ins_valid}, 32'd0);
        idle_step(0, 0, 0, 1);                          // c4
        chk("flush_valid_c4", {31'b0, ins_valid}, 32'd0);
        chk("flush_pcw_c4", {31'b0, PCWrite}, 32'd0);
        idle_step(0, 0, 0, 1);                          // c5
        chk("flush_new_req", {31'b0, mem_req}, 32'd1);
        chk("flush_new_addr", mem_addr, 32'h0040_0100);

        // Redirect together with ins_ready in HOLD
        do_reset();
        set_pc(32'h0040_0200);
        idle_step(0, 0, 0, 0);                          // c0
        idle_step(1, 0, 0, 0);                          // c1
        idle_step(0, 1, 32'h1234_5678, 0);              // c2
        step(0, 0, 0, 0, 1, 1, 32'h0040_0300);          // c3
        chk("hold_valid_c3", {31'b0, ins_valid}, 32'd1);
        idle_step(0, 0, 0, 0);                          // c4
        chk("redir_valid_drop", {31'b0, ins_valid}, 32'd0);
        chk("redir_no_pcw", {31'b0, PCWrite}, 32'd0);
        chk("redir_idle_noreq", {31'b0, mem_req}, 32'd0);
        idle_step(0, 0, 0, 0);                          // c5
        chk("redir_next_addr", mem_addr, 32'h0040_0300);

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers
        do_reset();
        set_pc(32'h0040_0400);
        idle_step(0, 0, 0, 0);                          // c0
        idle_step(1, 0, 0, 0);                          // c1
        for (int c = 2; c <= 9; c++) begin
            idle_step(0, 0, 0, 0);
            chk("to_no_err_yet", {31'b0, fetch_err}, 32'd0);
        end
        idle_step(0, 0, 0, 0);                          // c10
        chk("to_err_set", {31'b0, fetch_err}, 32'd1);
        for (int c = 11; c <= 15; c++) begin
            idle_step(0, 0, 0, 0);
            chk("to_no_retry", {31'b0, mem_req}, 32'd0);
            chk("to_err_sticky", {31'b0, fetch_err}, 32'd1);
        end
        do_reset();
        idle_step(0, 0, 0, 0);
        chk("to_err_cleared", {31'b0, fetch_err}, 32'd0);
`endif

        // Randomized traffic
        do_reset();
        set_pc(32'h0040_0000);
        for (int c = 0; c < 4000; c++) begin
            logic r_rst, r_gnt, r_rv, r_rdy, r_redir;
            logic [31:0] r_rd, r_tgt;
            r_rst   = ($urandom_range(0, 299) == 0);
            r_rv    = (mem_cnt == 0);
            r_gnt   = m_req && ($urandom_range(0, 2) == 0);
            r_redir = !m_pcw && !r_rv && ($urandom_range(0, 7) == 0);
            r_rdy   = ($urandom_range(0, 2) != 0);
            r_rd    = $urandom;
            r_tgt   = $urandom;
            step(r_rst, r_gnt, r_rv, r_rd, r_rdy, r_redir, r_tgt);
            if (r_rst) mem_cnt = -1;
            else begin
                if (r_rv) mem_cnt = -1;
                else if (mem_cnt > 0) mem_cnt--;
                if (r_gnt) mem_cnt = $urandom_range(0, 3);
            end
        end
        idle_step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
